qar_dmem_wait_slave: RTL and testbench
======================================

Name: qar_dmem_wait_slave

Overview:
- Synthesizable data-memory slave for the qar_core external data port (mem_valid/mem_we/mem_addr/mem_wdata/mem_ready/mem_rdata).
- Generalises the bench-only random-wait responder into parametrised RTL with configurable depth, width, wait-state mode and address-error reporting.
- Sits between qar_core and on-chip SRAM in FPGA builds and in regression benches.

Parameters:
- DEPTH, 256, number of words; power of two, 16..4096.
- DATA_W, 32, word width; the address is always 32 bits, byte-addressed.
- WAIT_MODE, 0, 0 = fixed wait of FIXED_WAIT cycles, 1 = pseudo-random wait in 0..MAX_WAIT.
- FIXED_WAIT, 0, wait cycles in mode 0, range 0..15.
- MAX_WAIT, 3, upper bound of the random wait in mode 1, range 0..15.
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.
- ERR_DATA, 32'hDEADBEEF, read data returned on an errored read, truncated to DATA_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  request; held by the master until mem_ready.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  32  byte address.
- mem_wdata  in  DATA_W  write data.
- mem_ready  out  1  single-cycle completion pulse.
- mem_rdata  out  DATA_W  read data; valid while mem_ready = 1.
- mem_err  out  1  pulses with mem_ready on an out-of-range or misaligned access.
- stats_clr  in  1  synchronous clear of the statistics counters.
- stat_reads  out  32  completed reads.
- stat_writes  out  32  completed writes.
- stat_stalls  out  32  cycles spent in WAIT.

Behaviour:
- Reset values: mem_ready = 0, mem_err = 0, mem_rdata = 0, state = IDLE, LFSR = LFSR_SEED, all statistics counters = 0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP, GAP.
- IDLE: if mem_valid = 1, latch we/addr/wdata, load the wait counter with W, go to WAIT when W > 0, otherwise go to RESP.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0. stat_stalls increments once per WAIT cycle.
- RESP: mem_ready = 1 for exactly one cycle.
  - A write commits to memory at the edge entering RESP.
  - mem_rdata is registered at that same edge.
  - Next state is GAP.
- GAP: one cycle in which mem_valid is ignored, so the master can drop valid; then IDLE.
- Latency from the accepting edge to mem_ready high is W+1 cycles. Back-to-back throughput is one transaction per W+3 cycles.
- Wait-state selection:
  - Mode 0: W = FIXED_WAIT.
  - Mode 1: W = min(lfsr[3:0], MAX_WAIT).
  - The LFSR is a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1. It advances only on accept edges.
- Address decoding: word index = mem_addr[log2(DEPTH)+1:2].
  - Error when mem_addr[1:0] != 0, or when any bit of mem_addr[31:log2(DEPTH)+2] is set.
  - On an errored access: the write is suppressed and memory is unchanged; a read returns ERR_DATA; mem_err = 1 alongside mem_ready.
- Outside RESP: mem_rdata holds its last value, mem_ready = 0 and mem_err = 0.
- Reset mid-transaction: the pending request is dropped with no write and no mem_ready, and the LFSR is reseeded. Memory is preserved, as required for multi-iteration benches.
- Counters saturate at 32'hFFFFFFFF. If stats_clr and an increment occur in the same cycle, the clear wins.

Optional Feature:
- Macro: QAR_DMEM_STATS_EN.
- Defined: the three counters operate as specified above.
- Undefined: the counter logic is removed; stat_* outputs are tied to 0 and stats_clr is ignored.
- Data-path timing is identical in both builds.

Decomposition:
- Package qar_mem_pkg:
  - FSM state encoding (IDLE = 0, WAIT = 1, RESP = 2, GAP = 3).
  - Mode constants MODE_FIXED = 0 and MODE_RANDOM = 1.
  - LFSR tap mask 16'hB400.
  - Default ERR_DATA.
- Sub-module qar_lfsr16: ports clk, rst_n, step, and the 16-bit state output; seed parameter.

Test Plan:
- Mode 0, FIXED_WAIT = 2: write 0x12345678 to 0x40, then read 0x40 -> mem_ready is high 3 cycles after each accept, mem_rdata = 0x12345678, mem_err = 0.
- Mode 1, MAX_WAIT = 3, seed 16'hACE1, 200 random reads and writes against a scoreboard -> every wait is in 0..3, all read data matches, stat_reads + stat_writes = 200.
- Read from 0x400 with DEPTH = 256, and write to 0x41 -> mem_err and mem_ready pulse together, read data = 0xDEADBEEF, word 0x10 is unchanged.
- rst_n asserted during WAIT of a write to 0x20 -> no mem_ready, word 8 keeps its old value, the next transaction's wait equals the first post-reset LFSR value.
- mem_valid held high through GAP -> no second accept in GAP; the request is accepted in the following IDLE cycle.
- With QAR_DMEM_STATS_EN: 5 transactions at FIXED_WAIT = 1, then stats_clr pulsed in the same cycle as a completion -> stat_stalls reads 5 before the clear and 0 after.

Source files
------------

// File: rtl/qar_mem_pkg.sv
// Shared definitions for the qar_core data-memory slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qar_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int MODE_FIXED  = 0;
  localparam int MODE_RANDOM = 1;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEADBEEF;

  // Random wait: low LFSR nibble clamped to the configured ceiling
  function automatic logic [3:0] clamp_wait(input logic [3:0] rnd, input logic [3:0] max_w);
    return (rnd > max_w) ? max_w : rnd;
  endfunction

endpackage

// File: rtl/qar_lfsr16.sv
// 16-bit Galois LFSR, advances by one position when step is high.
// Latency: new state visible the cycle after step.
// Backpressure: none; state holds while step is low.
module qar_lfsr16
  import qar_mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: shift right, fold the taps in when the bit shifted out is 1
  always_comb begin
    state_d = state_q;
    if (step) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State register, reseeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SEED;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/qar_dmem_wait_slave.sv
// Word-addressed data-memory slave for qar_core with fixed or pseudo-random wait states.
// Latency: mem_ready rises W+1 cycles after the accept cycle; one transaction per W+3 cycles.
// Backpressure: request held by master until mem_ready; one GAP cycle ignores valid. Stats counters
// are built only when QAR_DMEM_STATS_EN is defined, otherwise stat_* read 0.
module qar_dmem_wait_slave
  import qar_mem_pkg::*;
#(
  parameter int          DEPTH      = 256,
  parameter int          DATA_W     = 32,
  parameter int          WAIT_MODE  = MODE_FIXED,
  parameter int          FIXED_WAIT = 0,
  parameter int          MAX_WAIT   = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err,
  input  logic              stats_clr,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stalls
);

  localparam int                AW      = $clog2(DEPTH);
  localparam logic [3:0]        FIXED_W = 4'(FIXED_WAIT);
  localparam logic [3:0]        MAX_W   = 4'(MAX_WAIT);
  localparam logic [DATA_W-1:0] ERR_D   = DATA_W'(ERR_DATA);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, err_q, run_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [15:0]       lfsr_state;
  logic [3:0]        w_sel;

  logic              acc, go_resp, in_err, cur_we, cur_err;
  logic [AW-1:0]     in_idx, cur_idx;
  logic [DATA_W-1:0] cur_wdata;

  // Accepts are held off until the first cycle after reset release
  assign acc     = (state_q == IDLE) && mem_valid && run_q;
  assign in_idx  = mem_addr[AW+1:2];
  assign in_err  = (mem_addr[1:0] != 2'b00) || (mem_addr[31:AW+2] != '0);

  // A zero-wait request commits straight from the port, otherwise from the latched copy
  assign cur_we    = (state_q == IDLE) ? mem_we    : we_q;
  assign cur_err   = (state_q == IDLE) ? in_err    : err_q;
  assign cur_idx   = (state_q == IDLE) ? in_idx    : idx_q;
  assign cur_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
  assign go_resp   = (acc && (w_sel == 4'd0)) || ((state_q == WAIT) && (cnt_q == 4'd1));

  qar_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (acc),
    .state (lfsr_state)
  );

  // Wait-state count for the request being accepted this cycle
  always_comb begin
    w_sel = FIXED_W;
    if (WAIT_MODE == MODE_RANDOM) w_sel = clamp_wait(lfsr_state[3:0], MAX_W);
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (acc) begin
        cnt_d   = w_sel;
        state_d = (w_sel == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, request latch and read-data register; a reset drops any pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      if (acc) begin
        we_q    <= mem_we;
        err_q   <= in_err;
        idx_q   <= in_idx;
        wdata_q <= mem_wdata;
      end
      if (go_resp && !cur_we) rdata_q <= cur_err ? ERR_D : mem_q[cur_idx];
    end
  end

  // Storage array, deliberately not reset so contents survive a core reset
  always_ff @(posedge clk) begin
    if (go_resp && cur_we && !cur_err) mem_q[cur_idx] <= cur_wdata;
  end

  assign mem_ready = (state_q == RESP);
  assign mem_err   = (state_q == RESP) && err_q;
  assign mem_rdata = rdata_q;

`ifdef QAR_DMEM_STATS_EN
  logic [31:0] reads_q, writes_q, stalls_q;

  // Saturating statistics; a clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
      stalls_q <= '0;
    end else if (stats_clr) begin
      reads_q  <= '0;
      writes_q <= '0;
      stalls_q <= '0;
    end else begin
      if (state_q == RESP && !we_q && reads_q  != '1) reads_q  <= reads_q + 32'd1;
      if (state_q == RESP &&  we_q && writes_q != '1) writes_q <= writes_q + 32'd1;
      if (state_q == WAIT && stalls_q != '1)          stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_stalls = stalls_q;

  logic unused_ok;
  assign unused_ok = ^lfsr_state[15:4];
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_stalls = '0;

  logic unused_ok;
  assign unused_ok = ^{stats_clr, lfsr_state[15:4]};
`endif

endmodule

// File: tb/tb_qar_dmem_wait_slave.sv
// Bench for qar_dmem_wait_slave: fixed-wait, random-wait and stats instances on one clock.
module tb_qar_dmem_wait_slave;

  logic        clk = 1'b0;
  logic        rst_n, we, stats_clr;
  logic [31:0] addr, wdata;
  logic        valid [3];
  logic        rdy   [3];
  logic        err   [3];
  logic [31:0] rdata [3];
  logic [31:0] st_rd [3];
  logic [31:0] st_wr [3];
  logic [31:0] st_st [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qar_dmem_wait_slave #(.DEPTH(256), .DATA_W(32), .WAIT_MODE(0), .FIXED_WAIT(2), .MAX_WAIT(3),
                        .LFSR_SEED(16'hACE1), .ERR_DATA(32'hDEADBEEF)) u_fix (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid[0]), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_ready(rdy[0]), .mem_rdata(rdata[0]), .mem_err(err[0]),
    .stats_clr(stats_clr), .stat_reads(st_rd[0]), .stat_writes(st_wr[0]), .stat_stalls(st_st[0]));

  qar_dmem_wait_slave #(.DEPTH(256), .DATA_W(32), .WAIT_MODE(1), .FIXED_WAIT(0), .MAX_WAIT(3),
                        .LFSR_SEED(16'hACE1), .ERR_DATA(32'hDEADBEEF)) u_rnd (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid[1]), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_ready(rdy[1]), .mem_rdata(rdata[1]), .mem_err(err[1]),
    .stats_clr(stats_clr), .stat_reads(st_rd[1]), .stat_writes(st_wr[1]), .stat_stalls(st_st[1]));

  qar_dmem_wait_slave #(.DEPTH(256), .DATA_W(32), .WAIT_MODE(0), .FIXED_WAIT(1), .MAX_WAIT(3),
                        .LFSR_SEED(16'hACE1), .ERR_DATA(32'hDEADBEEF)) u_st (
    .clk(clk), .rst_n(rst_n), .mem_valid(valid[2]), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_ready(rdy[2]), .mem_rdata(rdata[2]), .mem_err(err[2]),
    .stats_clr(stats_clr), .stat_reads(st_rd[2]), .stat_writes(st_wr[2]), .stat_stalls(st_st[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction starting from IDLE; returns in IDLE at a falling edge
  task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er, output int lat);
    bit done = 1'b0;
    we = w; addr = a; wdata = d; valid[sel] = 1'b1;
    lat = 0; rd = '0; er = 1'b0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (rdy[sel]) begin
        done = 1'b1;
        rd   = rdata[sel];
        er   = err[sel];
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: inst %0d addr %h got no mem_ready within 40 cycles", sel, a);
    end
    valid[sel] = 1'b0;
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  vec_t        tv [13];
  logic [31:0] sb [16];
  logic [31:0] rd;
  logic        er;
  int          lat, n, seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0,          1'b0, 3};
    tv[1]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1'b0, 3};
    tv[2]  = '{1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,          1'b0, 3};
    tv[3]  = '{1'b0, 32'h0000_0044, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
    tv[4]  = '{1'b0, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 1'b1, 3};
    tv[5]  = '{1'b1, 32'h0000_0041, 32'h5555_5555, 32'h0,          1'b1, 3};
    tv[6]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1'b0, 3};
    tv[7]  = '{1'b0, 32'h0000_0042, 32'h0,         32'hDEAD_BEEF, 1'b1, 3};
    tv[8]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0,          1'b0, 3};
    tv[9]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0, 3};
    tv[10] = '{1'b0, 32'h8000_0040, 32'h0,         32'hDEAD_BEEF, 1'b1, 3};
    tv[11] = '{1'b1, 32'h0000_0440, 32'h0BAD_F00D, 32'h0,          1'b1, 3};
    tv[12] = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1'b0, 3};

    rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; stats_clr = 1'b0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (2) step();

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), {31'b0, rdy[i]}, 32'd0);
      chk($sformatf("rst_err%0d", i),   {31'b0, err[i]}, 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_stats%0d", i), st_rd[i] | st_wr[i] | st_st[i], 32'd0);
    end
    rst_n = 1'b1;
    step();

    // Fixed wait of 2: functional vectors, address errors and boundaries
    for (int i = 0; i < 13; i++) begin
      txn(0, tv[i].we, tv[i].addr, tv[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_lat", i), lat, tv[i].exp_lat);
      chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tv[i].exp_err});
      if (!tv[i].we) chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
    end
    chk("rdata_hold_idle", rdata[0], 32'h1234_5678);
    chk("err_low_idle", {31'b0, err[0]}, 32'd0);

    // Valid held through GAP: next accept only in the following IDLE
    we = 1'b0; addr = 32'h44; valid[0] = 1'b1; n = 0;
    while (!rdy[0] && n < 20) begin step(); n++; end
    chk("gap_first_rdata", rdata[0], 32'hCAFE_F00D);
    n = 0;
    do begin step(); n++; end while (!rdy[0] && n < 20);
    chk("gap_interval", n, 5);
    valid[0] = 1'b0;
    repeat (2) step();

    // Reset during WAIT of a write on the random-wait instance
    do_reset();
    txn(1, 1'b1, 32'h20, 32'h1111_2222, rd, er, lat);
    chk("rnd_w1_lat", lat, 2);
    txn(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rnd_w0_lat", lat, 1);
    chk("rnd_w0_rdata", rd, 32'h1111_2222);
    we = 1'b1; addr = 32'h20; wdata = 32'h9999_9999; valid[1] = 1'b1;
    step();
    chk("abort_in_wait", {31'b0, rdy[1]}, 32'd0);
    seen = 0;
    rst_n = 1'b0; valid[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst_n = 1'b1;
      step();
      if (rdy[1]) seen++;
    end
    chk("abort_no_ready", seen, 0);
    txn(1, 1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("abort_word8_kept", rd, 32'h1111_2222);
    chk("abort_reseed_lat", lat, 2);
    txn(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("mem_survives_reset", rd, 32'h1234_5678);

    // 200 random transactions against a scoreboard
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic        w;
      logic [3:0]  idx;
      logic [31:0] d;
      idx = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
      w   = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      d   = $urandom;
      txn(1, w, 32'h100 + {26'b0, idx, 2'b00}, d, rd, er, lat);
      chk($sformatf("rnd%0d_lat_in_range", i), {31'b0, (lat >= 1 && lat <= 4)}, 32'd1);
      chk($sformatf("rnd%0d_err", i), {31'b0, er}, 32'd0);
      if (w) sb[idx] = d;
      else   chk($sformatf("rnd%0d_rdata", i), rd, sb[idx]);
    end
`ifdef QAR_DMEM_STATS_EN
    chk("rnd_completions", st_rd[1] + st_wr[1], 32'd200);
`else
    chk("rnd_completions", st_rd[1] + st_wr[1], 32'd0);
`endif

    // Stats: five transactions at wait 1, clear coinciding with the fifth completion
    txn(2, 1'b1, 32'h0, 32'h0000_0001, rd, er, lat);
    chk("st_lat", lat, 2);
    txn(2, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("st_rdata0", rd, 32'h0000_0001);
    txn(2, 1'b1, 32'h4, 32'h0000_0002, rd, er, lat);
    txn(2, 1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("st_rdata1", rd, 32'h0000_0002);
    we = 1'b0; addr = 32'h0; valid[2] = 1'b1; n = 0;
    while (!rdy[2] && n < 20) begin step(); n++; end
`ifdef QAR_DMEM_STATS_EN
    chk("stalls_before_clr", st_st[2], 32'd5);
    chk("done_before_clr", st_rd[2] + st_wr[2], 32'd4);
`else
    chk("stalls_before_clr", st_st[2], 32'd0);
    chk("done_before_clr", st_rd[2] + st_wr[2], 32'd0);
`endif
    stats_clr = 1'b1; valid[2] = 1'b0;
    step();
    stats_clr = 1'b0;
    chk("stalls_after_clr", st_st[2], 32'd0);
    chk("done_after_clr", st_rd[2] + st_wr[2], 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
